// File: rtl/digtal_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line, paced by Baud16X.
// Optional even-parity bit: define DIGTAL_UART_TX_PARITY_EN.
module digtal_uart_tx_arbiter #(
    parameter int REQ_NUM   = 4,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clock,
    input  logic                 Reset_N,
    input  logic                 Baud16X,
    input  logic [REQ_NUM-1:0]   Req,
    input  logic [REQ_NUM*8-1:0] Data,
    output logic [REQ_NUM-1:0]   Ack,
    output logic [2:0]           Grant_Id,
    output logic                 Busy,
    output logic                 TxD
);

`ifdef DIGTAL_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, ALIGN, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ALIGN, START, DATA, STOP
    } state_t;
`endif

    state_t                 state;
    state_t                 state_nxt;
    logic                   baud_d;
    logic                   tick;
    logic                   bit_end;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic [2:0]             rr_ptr;
    logic                   hi_hit;
    logic                   lo_hit;
    logic [2:0]             hi_idx;
    logic [2:0]             lo_idx;
    logic                   gnt_valid;
    logic [2:0]             gnt_idx;
    logic [DATA_BITS-1:0]   sel_data;
    logic [REQ_NUM-1:0]     ack_nxt;
`ifdef DIGTAL_UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    assign tick    = Baud16X & ~baud_d;
    assign bit_end = tick & (tick_cnt == 4'd15);

    // Round-robin pick: lowest requester at/after the pointer, else lowest overall
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = 3'd0;
        lo_idx = 3'd0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (Req[i]) begin
                if (3'(i) >= rr_ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = 3'(i);
                end
                lo_hit = 1'b1;
                lo_idx = 3'(i);
            end
        end
        gnt_valid = lo_hit;
        gnt_idx   = hi_hit ? hi_idx : lo_idx;
    end

    // Select the granted byte slice and build the one-hot acknowledge
    always_comb begin
        sel_data = '0;
        ack_nxt  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (gnt_idx == 3'(i)) begin
                sel_data   = Data[i*8 +: DATA_BITS];
                ack_nxt[i] = gnt_valid;
            end
        end
    end

    // State register
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; every bit boundary lands on a tick-counter wrap
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (gnt_valid) state_nxt = ALIGN;
            ALIGN: if (tick)      state_nxt = START;
            START: if (bit_end)   state_nxt = DATA;
            DATA: begin
                if (bit_end && bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef DIGTAL_UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef DIGTAL_UART_TX_PARITY_EN
            PARITY: if (bit_end) state_nxt = STOP;
`endif
            STOP: begin
                if (bit_end && bit_cnt == 3'(STOP_BITS - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant capture, tick/bit counters, shift register
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            baud_d   <= 1'b0;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift_q  <= '0;
            rr_ptr   <= 3'd0;
            Ack      <= '0;
            Grant_Id <= 3'd0;
`ifdef DIGTAL_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            baud_d <= Baud16X;
            Ack    <= '0;
            if (state == IDLE) begin
                if (gnt_valid) begin
                    shift_q  <= sel_data;
                    Grant_Id <= gnt_idx;
                    Ack      <= ack_nxt;
                    rr_ptr   <= (gnt_idx == 3'(REQ_NUM - 1)) ?
                                3'd0 : gnt_idx + 3'd1;
`ifdef DIGTAL_UART_TX_PARITY_EN
                    parity_q <= ^sel_data;
`endif
                end
            end else if (state == ALIGN) begin
                bit_cnt <= 3'd0;
                if (tick) tick_cnt <= 4'd0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (bit_end) begin
                    bit_cnt <= (state_nxt != state) ?
                               3'd0 : bit_cnt + 3'd1;
                    if (state == DATA) shift_q <= shift_q >> 1;
                end
            end
        end
    end

    // Line level and busy flag decoded from the current state
    always_comb begin
        Busy = (state != IDLE);
        TxD  = 1'b1;
        case (state)
            START:  TxD = 1'b0;
            DATA:   TxD = shift_q[0];
`ifdef DIGTAL_UART_TX_PARITY_EN
            PARITY: TxD = parity_q;
`endif
            default: TxD = 1'b1;
        endcase
    end

endmodule

// File: doc/digtal_uart_tx_arbiter.md
Name: digtal_uart_tx_arbiter

Overview:
- Shares one UART transmit line among REQ_NUM requesters, granting them round-robin.
- Paces every frame from the Baud16X output of the baud generator, which runs in the same Clock domain.
- Serialises one frame per grant: start bit, DATA_BITS data bits LSB-first, optional parity, then stop bit(s).
- Sits between the protocol/command blocks of the Cyclone IV digital interface and the external TxD pin.

Parameters:
- REQ_NUM, 4, number of requesters; legal range 2..8.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- Clock  input  1  digital interface clock; same clock that drives the baud generator.
- Reset_N  input  1  reset, asynchronous, active-low. One clock; all state clears asynchronously on Reset_N low.
- Baud16X  input  1  16x baud signal from the baud generator; a level signal in the Clock domain.
- Req  input  REQ_NUM  per-requester transmit request; level, held high until the matching Ack.
- Data  input  REQ_NUM*8  per-requester byte; requester i occupies bits [8i+7:8i]; only [8i+DATA_BITS-1:8i] is sent.
- Ack  output  REQ_NUM  one-cycle pulse to the granted requester when its byte is captured.
- Grant_Id  output  3  index of the current/last granted requester.
- Busy  output  1  high while a frame is in progress.
- TxD  output  1  serial line; idles high.

Behaviour:
- Reset values: TxD=1, Busy=0, Ack=0, Grant_Id=0, FSM=IDLE, tick counter=0, round-robin pointer=0.
- Tick generation:
  - Baud16X is registered once.
  - Tick = Baud16X & ~Baud16X_d, a one-Clock pulse on each rising edge.
  - Must work when Baud16X toggles every Clock (rising edge every 2 Clocks).
- IDLE:
  - When any Req bit is high, grant the first requester at or after the pointer, wrapping REQ_NUM-1 -> 0.
  - In the same cycle: latch its Data slice, set Grant_Id, pulse Ack[i]=1 for exactly one cycle, set Busy=1, go to ALIGN.
  - Pointer <= granted index + 1, with wrap.
  - Req is sampled only in IDLE. A Req dropped before grant is ignored.
- ALIGN: wait for the next Tick. On that Tick, TxD goes to 0 in the following cycle, the tick counter clears, and the FSM goes to START.
- Bit timing:
  - Each bit lasts exactly 16 Ticks.
  - 4-bit tick counter counts 0..15 on Ticks; the wrap 15->0 advances the bit.
  - No sampling-phase logic; this is TX only.
- START: TxD=0 for 16 Ticks, then go to DATA.
- DATA:
  - Shift out the latched byte LSB-first, one bit per 16 Ticks.
  - 3-bit bit counter; after bit DATA_BITS-1, go to PARITY if PARITY_EN is defined, otherwise go to STOP.
- PARITY: TxD = XOR of the DATA_BITS sent bits (even parity) for 16 Ticks, then go to STOP.
- STOP: TxD=1 for STOP_BITS*16 Ticks, then go to IDLE with Busy=0 in the same cycle.
  - Total frame = (1+DATA_BITS+STOP_BITS[+1])*16 Ticks.
- Back-to-back: a pending Req is arbitrated on the first IDLE cycle after STOP, so there is no extra gap beyond ALIGN.
- Data changes after Ack do not affect the frame in flight.
- Req of the currently-transmitting requester that stays high after Ack is a new request. It is served only after the other pending requesters, per round-robin.
- Reset mid-frame: TxD returns to 1 asynchronously, the frame is abandoned with no Ack re-issue, and the pointer returns to 0.
- Baud16X stuck (no Ticks): FSM holds its state and TxD holds its level indefinitely; no timeout.

Optional Feature:
- Macro: DIGTAL_UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP with even parity; frame length grows by 16 Ticks.
- Undefined: the PARITY state and its logic are absent; DATA goes straight to STOP.

Test Plan:
- Single request, Baud16X toggling every Clock, 8N1, Req[0]=1 with Data[7:0]=0x55:
  - Ack[0] is one pulse.
  - TxD shows 0,1,0,1,0,1,0,1,0,1, each bit 32 Clocks.
  - Busy falls 320 Clocks after the first Tick.
- Round-robin: Req=4'b1111 held continuously, re-asserted after each Ack:
  - Grant_Id sequence is 0,1,2,3,0.
  - Each Ack is one cycle; no requester is starved.
- Pointer wrap: last grant 3, then Req=4'b1001 -> Grant_Id=0 next, then 3.
- Reset mid-frame: assert Reset_N=0 during DATA bit 3 of 0xA5:
  - TxD=1 and Busy=0 immediately.
  - After release, Req[2] -> full new frame, Grant_Id=2.
- Parity build with DIGTAL_UART_TX_PARITY_EN defined, Data=0x07:
  - Parity bit=1.
  - Frame = 11 bits * 16 Ticks; stop bit high for 16 Ticks.
- Slow baud: Baud16X rising edge every 16 Clocks, STOP_BITS=2:
  - Each bit lasts 256 Clocks.
  - Stop interval lasts 512 Clocks.
  - Changing Data mid-frame does not alter TxD.
